option_feeder: RTL
==================

Name: option_feeder

Overview:
- Drives the option stream into the solver: for each line it sends a line-index word, then that line's option words, one word per cycle.
- Options the solver keeps (put_back_to_FIFO) are written back to the tail of an internal option FIFO, so the FIFO always holds the surviving candidates.
- Maintains the per-line option counts and the total remaining count the solver reads.
- Sits between the board/option loader (upstream) and the solver (downstream).

Parameters:
- MAX_SIZE, 11, maximum board side; lines = 2*MAX_SIZE (rows then columns).
- WORD_W, 16, option/index word width.
- DEPTH, 512, option FIFO depth (power of two).
- CNT_W, 7, width of per-line and total option counts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- num_rows  in  4  active rows (1..MAX_SIZE).
- num_cols  in  4  active columns (1..MAX_SIZE).
- load_valid  in  1  loader word strobe.
- load_is_idx  in  1  load_data is a line index (else an option for the last index).
- load_data  in  WORD_W  loader word.
- load_ready  out  1  high only in LOAD.
- go  in  1  end of load; start streaming.
- started  out  1  one-cycle pulse to solver at first SEND_IDX.
- option  out  WORD_W  index or option word to solver.
- new_line  in  1  solver acknowledges an index word.
- new_option  in  WORD_W  option the solver keeps.
- put_back_to_FIFO  in  1  push new_option this cycle.
- solved  in  1  solver done.
- unsolvable  in  1  solver contradiction.
- old_options_amnt  out  [2*MAX_SIZE-1:0][CNT_W-1:0]  options per line.
- all_options_remaining  out  CNT_W  sum of old_options_amnt, saturating at 2^CNT_W-1.
- done  out  1  sticky; set in DONE.
- overflow  out  1  sticky; load attempted with FIFO full.

Behaviour:
- Reset:
  - State IDLE.
  - FIFO empty.
  - All counts 0; option 0.
  - started, done, overflow, load_ready all 0.
- States and transitions:
  - IDLE -> LOAD on the first cycle after reset.
  - LOAD:
    - Each load_valid with load_is_idx=0 pushes load_data and increments old_options_amnt[cur_load_line].
    - load_is_idx=1 sets cur_load_line and pushes nothing.
    - Full FIFO: the word is dropped and overflow is set.
    - go -> SEND_IDX with line=0; started pulses for one cycle.
  - SEND_IDX:
    - option=line index for one cycle; kept counter cleared.
    - If old_options_amnt[line]==0, the index is still sent.
    - Next: SEND_OPT if count>0, else ADVANCE.
  - SEND_OPT:
    - Pop the FIFO head to option, one per cycle, count times.
    - put_back_to_FIFO pushes new_option and increments kept in the same cycle. A simultaneous pop and push is legal.
    - After the last pop -> ADVANCE. A put_back arriving in ADVANCE's cycle is still accepted (one-cycle solver latency).
  - ADVANCE:
    - old_options_amnt[line] <= kept.
    - line wraps to 0 after num_rows+num_cols-1.
    - Next: SEND_IDX.
  - solved or unsolvable in any send state -> DONE after the current cycle; done=1.
  - DONE holds until rst.
- Width rules:
  - Row option words use the low num_cols bits; column option words use the low num_rows bits; upper bits are 0.
  - Counts saturate and never wrap.
- new_line is monitored only; a missing ack does not stall the stream.
- rst mid-operation: all state returns to reset values asynchronously; FIFO contents are discarded.

Decomposition:
- feeder_pkg: state enum {IDLE, LOAD, SEND_IDX, SEND_OPT, ADVANCE, DONE}, WORD_W, CNT_W, MAX_SIZE.
- Sub-module option_fifo: single-clock, async-reset, push/pop same cycle, full/empty flags, count output.

Test Plan:
- 11x11 cross board, 1 option/line:
  - Load 22 index/option pairs, go.
  - Stream is 0,11'b11111111111,1,11'b10111111101,...; started pulses once.
  - all_options_remaining=22.
- Keep filter:
  - Line 0 has 3 options; the solver puts back 2.
  - After ADVANCE old_options_amnt[0]=2 and the FIFO tail holds those 2 words in order.
- Wrap-around:
  - num_rows=num_cols=2; no solved.
  - Index sequence 0,1,2,3,0,1...
- Termination:
  - solved asserted mid-SEND_OPT.
  - done=1 next cycle; option stops changing; load_ready=0.
- Overflow:
  - DEPTH=4; load 5 options.
  - overflow=1; count for that line=4.
- Async reset:
  - Assert rst mid-SEND_OPT between clock edges.
  - Outputs zero immediately; returns to LOAD after release.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and constants for the option feeder.
// Holds the controller state enum, board/word/count dimensions and two small
// helpers: a saturating count increment and a low-bit word mask.
package feeder_pkg;

    localparam int MAX_SIZE  = 11;
    localparam int LINES     = 2 * MAX_SIZE;
    localparam int LINE_W    = $clog2(LINES);
    localparam int WORD_W    = 16;
    localparam int CNT_W     = 7;
    localparam int DEF_DEPTH = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_IDX,
        SEND_OPT,
        ADVANCE,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Keep only the low 'width' bits of an option word.
    function automatic logic [WORD_W-1:0] mask_low(input logic [WORD_W-1:0] w,
                                                   input logic [3:0]        width);
        return w & ((WORD_W'(1) << width) - WORD_W'(1));
    endfunction

endpackage

// File: rtl/option_fifo.sv
// Single-clock option FIFO.
// Ports: push/push_data write at the tail, pop advances the head (pop_data
// shows the head combinationally), full/empty flags and an occupancy count.
// A push and a pop in the same cycle are both honoured; a push while full or a
// pop while empty is ignored.
module option_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/option_feeder.sv
// Option feeder: streams a line index followed by that line's options to the
// solver, one word per cycle, and recycles the options the solver keeps to the
// tail of the option FIFO.
// Ports: num_rows/num_cols set the active board; load_* and go come from the
// loader; option/started go to the solver; new_option/put_back_to_FIFO return
// kept options; solved/unsolvable end the run; old_options_amnt and
// all_options_remaining report counts; done/overflow are sticky status.
//
// state    | meaning
// IDLE     | just out of reset
// LOAD     | accepting loader words into the FIFO
// SEND_IDX | option carries the current line index
// SEND_OPT | option carries FIFO words for the current line
// ADVANCE  | commit kept count, step to next line
// DONE     | solver finished; frozen until reset
module option_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  num_rows,
    input  logic [3:0]                  num_cols,
    input  logic                        load_valid,
    input  logic                        load_is_idx,
    input  logic [WORD_W-1:0]           load_data,
    output logic                        load_ready,
    input  logic                        go,
    output logic                        started,
    output logic [WORD_W-1:0]           option,
    input  logic                        new_line,
    input  logic [WORD_W-1:0]           new_option,
    input  logic                        put_back_to_FIFO,
    input  logic                        solved,
    input  logic                        unsolvable,
    output logic [LINES-1:0][CNT_W-1:0] old_options_amnt,
    output logic [CNT_W-1:0]            all_options_remaining,
    output logic                        done,
    output logic                        overflow
);

    localparam int FAW   = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + LINE_W;

    state_t            state, state_nx;
    logic [LINE_W-1:0] line, line_nx, last_line, cur_load_line;
    logic [CNT_W-1:0]  rem, kept, line_cnt;
    logic [3:0]        line_width, load_width;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_wdata, fifo_rdata;
    logic [FAW:0]      fifo_count;
    logic              stop, load_opt, pb_push;
    logic [SUM_W-1:0]  total;
    logic              unused;

    // new_line is an acknowledge the stream never waits on.
    assign unused = ^{new_line, fifo_empty, fifo_count, load_data[WORD_W-1:LINE_W]};

    assign load_ready = (state == LOAD);
    assign last_line  = LINE_W'(num_rows) + LINE_W'(num_cols) - LINE_W'(1);
    assign line_nx    = (line >= last_line) ? '0 : line + LINE_W'(1);
    assign line_cnt   = old_options_amnt[line];

    // Rows carry column-wide words and columns carry row-wide words.
    assign line_width = (line < LINE_W'(num_rows)) ? num_cols : num_rows;
    assign load_width = (cur_load_line < LINE_W'(num_rows)) ? num_cols : num_rows;

    assign load_opt = (state == LOAD) && load_valid && !load_is_idx;
    assign stop     = (solved || unsolvable) &&
                      (state == SEND_IDX || state == SEND_OPT || state == ADVANCE);
    // Put-backs trail their option by one cycle, so ADVANCE still accepts one.
    assign pb_push  = put_back_to_FIFO && !fifo_full && !stop &&
                      (state == SEND_OPT || state == ADVANCE);

    option_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_nx   = state;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_wdata = mask_low(new_option, line_width);
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: begin
                fifo_push  = load_opt && !fifo_full;
                fifo_wdata = mask_low(load_data, load_width);
                if (go) state_nx = SEND_IDX;
            end
            SEND_IDX: begin
                if (stop) begin
                    state_nx = DONE;
                end else if (line_cnt != '0) begin
                    fifo_pop = 1'b1;
                    state_nx = SEND_OPT;
                end else begin
                    state_nx = ADVANCE;
                end
            end
            SEND_OPT: begin
                fifo_push = pb_push;
                if (stop) begin
                    state_nx = DONE;
                end else if (rem != '0) begin
                    fifo_pop = 1'b1;
                end else begin
                    state_nx = ADVANCE;
                end
            end
            ADVANCE: begin
                fifo_push = pb_push;
                state_nx  = stop ? DONE : SEND_IDX;
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            line             <= '0;
            cur_load_line    <= '0;
            rem              <= '0;
            kept             <= '0;
            option           <= '0;
            started          <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            old_options_amnt <= '0;
        end else begin
            state   <= state_nx;
            started <= 1'b0;
            if (stop) done <= 1'b1;
            case (state)
                LOAD: begin
                    if (load_valid && load_is_idx) cur_load_line <= load_data[LINE_W-1:0];
                    if (load_opt) begin
                        if (fifo_full) begin
                            overflow <= 1'b1;
                        end else if (cur_load_line < LINE_W'(LINES)) begin
                            old_options_amnt[cur_load_line] <=
                                sat_inc(old_options_amnt[cur_load_line]);
                        end
                    end
                    if (go) begin
                        line    <= '0;
                        option  <= '0;
                        started <= 1'b1;
                    end
                end
                SEND_IDX: begin
                    kept <= '0;
                    if (fifo_pop) begin
                        option <= fifo_rdata;
                        rem    <= line_cnt - CNT_W'(1);
                    end
                end
                SEND_OPT: begin
                    if (pb_push) kept <= sat_inc(kept);
                    if (fifo_pop) begin
                        option <= fifo_rdata;
                        rem    <= rem - CNT_W'(1);
                    end
                end
                ADVANCE: begin
                    if (!stop) begin
                        old_options_amnt[line] <= pb_push ? sat_inc(kept) : kept;
                        line   <= line_nx;
                        option <= WORD_W'(line_nx);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        total = '0;
        for (int i = 0; i < LINES; i++) begin
            total = total + SUM_W'(old_options_amnt[i]);
        end
        all_options_remaining = (|total[SUM_W-1:CNT_W]) ? '1 : total[CNT_W-1:0];
    end

endmodule
